dmem_responder: RTL

- Multi-cycle data-memory responder: the memory end of the hart's dmem port (aligned address, ren/wen, byte mask, wdata/rdata).
- Replaces the combinational dmem model so the hart is exercised against realistic latency.
- Owns a word-organised storage array, applies byte masks, returns read data after a fixed latency, and drives a combinational stall (o_busy) back to the hart.

---
 rtl/dmem_responder_if.sv | 18 +
 rtl/dmem_responder.sv | 123 ++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// Hart <-> data-memory bus: request fields from the hart, stall/response fields from the responder.
interface dmem_responder_if;
  logic [31:0] i_addr;
  logic        i_ren;
  logic        i_wen;
  logic [31:0] i_wdata;
  logic [3:0]  i_mask;
  logic        o_busy;
  logic        o_rvalid;
  logic [31:0] o_rdata;
  logic        o_wdone;
  logic        o_err;

  modport master (output i_addr, i_ren, i_wen, i_wdata, i_mask,
                  input  o_busy, o_rvalid, o_rdata, o_wdone, o_err);
  modport slave  (input  i_addr, i_ren, i_wen, i_wdata, i_mask,
                  output o_busy, o_rvalid, o_rdata, o_wdone, o_err);
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with fixed LATENCY, byte masks and a combinational stall.
// Define DMEM_BOUNDS_CHECK_EN to flag (and suppress) accesses at byte addresses >= 4*DEPTH.
module dmem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  dmem_responder_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [3:0]    mask_q;
  logic          wr_q;
  logic          oob_q;
  logic [31:0]   rdata_q;
  logic [31:0]   mem_q [DEPTH];

  logic          req_ok, req_bad, accept, commit, oob_now;
  logic [AW-1:0] c_idx;
  logic [31:0]   c_wdata, lane_en;
  logic [3:0]    c_mask;
  logic          c_wr, c_oob;
  logic          unused_addr;

  assign unused_addr = ^{bus.i_addr[1:0], bus.i_addr[31:AW+2]};

`ifdef DMEM_BOUNDS_CHECK_EN
  assign oob_now = |bus.i_addr[31:AW+2];
`else
  assign oob_now = 1'b0;
`endif

  assign req_ok  = bus.i_ren ^ bus.i_wen;
  assign req_bad = bus.i_ren & bus.i_wen;
  assign accept  = (state_q == S_IDLE) && req_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_ok) begin
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // RESP is entered either straight from IDLE (LATENCY=1, live inputs) or from WAIT (latched copy).
  assign commit = (state_d == S_RESP);

  always_comb begin
    if (state_q == S_IDLE) begin
      c_idx   = bus.i_addr[AW+1:2];
      c_wdata = bus.i_wdata;
      c_mask  = bus.i_mask;
      c_wr    = bus.i_wen;
      c_oob   = oob_now;
    end else begin
      c_idx   = idx_q;
      c_wdata = wdata_q;
      c_mask  = mask_q;
      c_wr    = wr_q;
      c_oob   = oob_q;
    end
  end

  assign lane_en = {{8{c_mask[3]}}, {8{c_mask[2]}}, {8{c_mask[1]}}, {8{c_mask[0]}}};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit && !c_wr) rdata_q <= c_oob ? '0 : (mem_q[c_idx] & lane_en);
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      idx_q   <= bus.i_addr[AW+1:2];
      wdata_q <= bus.i_wdata;
      mask_q  <= bus.i_mask;
      wr_q    <= bus.i_wen;
      oob_q   <= oob_now;
    end
  end

  // Storage is deliberately not reset; reset only blocks a commit on the same edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst && commit && c_wr && !c_oob) begin
      if (c_mask[0]) mem_q[c_idx][7:0]   <= c_wdata[7:0];
      if (c_mask[1]) mem_q[c_idx][15:8]  <= c_wdata[15:8];
      if (c_mask[2]) mem_q[c_idx][23:16] <= c_wdata[23:16];
      if (c_mask[3]) mem_q[c_idx][31:24] <= c_wdata[31:24];
    end
  end

  assign bus.o_busy   = accept || (state_q == S_WAIT);
  assign bus.o_rvalid = (state_q == S_RESP) && !wr_q && !oob_q;
  assign bus.o_wdone  = (state_q == S_RESP) && wr_q && !oob_q;
  assign bus.o_err    = ((state_q == S_IDLE) && req_bad) || ((state_q == S_RESP) && oob_q);
  assign bus.o_rdata  = rdata_q;

endmodule
